// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and IF/ID pipeline register for a 16-bit core.
// Fetches one instruction word per cycle, resolves conditional PC-relative (B)
// and register-indirect (BR) branches from the IF/ID stage with a one-bubble
// penalty, holds on a hazard stall and stops in HALTED on HLT until reset.
// Optional feature macro: BRANCH_COUNT_EN builds a saturating taken-branch
// counter on branch_cnt; when undefined branch_cnt is tied to 0x0000.
//
// Handshake note: there is no valid/ready pair here. id_valid qualifies the
// IF/ID contents; stall is an unconditional hold that freezes PC and IF/ID and
// suppresses every decision (branch, hlt) for that cycle.
module pc_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_plus2,
    output logic        id_valid,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic        hlt,
    input  logic [2:0]  flags,
    input  logic [15:0] reg_target,
    input  logic        stall,
    output logic        taken,
    output logic        halted,
    output logic [15:0] branch_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] id_instr_q;
    logic [15:0] id_pc_plus2_q;
    logic        id_valid_q;
    logic        halted_q;

    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        cond_true;
    logic        branch_taken;
    logic [15:0] pc_plus2_d;
    logic [15:0] target_d;

    assign cond   = id_instr_q[11:9];
    assign imm9   = id_instr_q[8:0];
    assign flag_z = flags[2];
    assign flag_v = flags[1];
    assign flag_n = flags[0];

    // Branch condition evaluation from the {Z,V,N} flags
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // hlt wins over a (malformed) simultaneous branch decode
    assign branch_taken = id_valid_q & branch & ~hlt & cond_true & ~stall
                        & (state_q != ST_HALTED);

    // Next sequential PC and branch target; both wrap modulo 2^16
    always_comb begin
        pc_plus2_d = pc_q + 16'd2;
        if (branch_reg) begin
            target_d = reg_target;
        end else begin
            target_d = id_pc_plus2_q + {{6{imm9[8]}}, imm9, 1'b0};
        end
    end

    // Fetch FSM: PC, IF/ID register, run/stall/halt state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= 16'h0000;
            id_instr_q    <= 16'h0000;
            id_pc_plus2_q <= 16'h0000;
            id_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (stall) begin
                        state_q <= ST_STALL;
                    end else if (id_valid_q && hlt) begin
                        state_q    <= ST_HALTED;
                        halted_q   <= 1'b1;
                        id_valid_q <= 1'b0;
                    end else begin
                        state_q <= ST_RUN;
                        if (branch_taken) begin
                            pc_q       <= target_d;
                            id_valid_q <= 1'b0;
                        end else begin
                            pc_q          <= pc_plus2_d;
                            id_instr_q    <= imem_rdata;
                            id_pc_plus2_q <= pc_plus2_d;
                            id_valid_q    <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [15:0] branch_cnt_q;

    // Saturating count of taken branches
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= 16'h0000;
        end else if (branch_taken && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_q <= branch_cnt_q + 16'd1;
        end
    end

    assign branch_cnt = branch_cnt_q;
`else
    assign branch_cnt = 16'h0000;
`endif

    assign imem_addr   = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus2 = id_pc_plus2_q;
    assign id_valid    = id_valid_q;
    assign taken       = branch_taken;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized control/flag/stall/reset traffic, compared every cycle against a
// behavioural model of the fetch rules. Build with or without BRANCH_COUNT_EN.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        id_valid;
    logic        branch;
    logic        branch_reg;
    logic        hlt;
    logic [2:0]  flags;
    logic [15:0] reg_target;
    logic        stall;
    logic        taken;
    logic        halted;
    logic [15:0] branch_cnt;

    logic [15:0] mem [0:32767];

    int n_vec = 0;
    int n_bad = 0;

    // Model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    bit          m_valid;
    bit          m_halted;
    bit          m_fresh;
    int          m_cnt;
    bit          checks_on = 1'b0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[15:1]];

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_instr    (id_instr),
        .id_pc_plus2 (id_pc_plus2),
        .id_valid    (id_valid),
        .branch      (branch),
        .branch_reg  (branch_reg),
        .hlt         (hlt),
        .flags       (flags),
        .reg_target  (reg_target),
        .stall       (stall),
        .taken       (taken),
        .halted      (halted),
        .branch_cnt  (branch_cnt)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_taken();
        return m_valid && branch && !hlt && !stall && !m_halted
            && m_cond_ok(m_instr[11:9], flags);
    endfunction

    function automatic logic [15:0] m_target();
        int imm;
        if (branch_reg) return reg_target;
        imm = int'(m_instr[8:0]);
        if (imm > 255) imm -= 512;
        return 16'(int'(m_pp2) + imm * 2);
    endfunction

    function automatic logic [15:0] m_exp_cnt();
`ifdef BRANCH_COUNT_EN
        return 16'(m_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    // Control-unit stand-in: 0xC = B, 0xD = BR, 0xF = HLT, anything else plain
    task automatic drive_decode();
        branch     = (m_instr[15:12] == 4'hC) || (m_instr[15:12] == 4'hD);
        branch_reg = (m_instr[15:12] == 4'hD);
        hlt        = (m_instr[15:12] == 4'hF);
    endtask

    task automatic sample();
        #1;
        if (checks_on) begin
            check_eq("imem_addr", imem_addr, m_pc);
            check_eq("id_valid", 16'(id_valid), 16'(m_valid));
            check_eq("halted", 16'(halted), 16'(m_halted));
            check_eq("taken", 16'(taken), 16'(m_taken()));
            check_eq("branch_cnt", branch_cnt, m_exp_cnt());
            if (m_valid || m_fresh) begin
                check_eq("id_instr", id_instr, m_instr);
                check_eq("id_pc_plus2", id_pc_plus2, m_pp2);
            end
        end
    endtask

    task automatic advance();
        bit          tk;
        logic [15:0] tgt;
        tk  = m_taken();
        tgt = m_target();
        @(posedge clk);
        m_fresh = 1'b0;
        if (rst) begin
            m_pc = 16'h0; m_instr = 16'h0; m_pp2 = 16'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0; m_fresh = 1'b1;
        end else if (m_halted || stall) begin
            // everything held
        end else if (m_valid && hlt) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else if (tk) begin
            m_pc    = tgt;
            m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_instr = mem[m_pc[15:1]];
            m_pp2   = m_pc + 16'd2;
            m_pc    = m_pc + 16'd2;
            m_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch = 1'b0; branch_reg = 1'b0; hlt = 1'b0;
        sample();
        advance();
        rst = 1'b0;
        checks_on = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_decode();
            sample();
            advance();
        end
    endtask

    // Leaves the bench sampled but not advanced on the taken cycle
    task automatic run_until_taken(input int budget);
        for (int i = 0; i < budget; i++) begin
            drive_decode();
            sample();
            if (m_taken()) return;
            advance();
        end
        n_vec++;
        n_bad++;
        $display("FAIL run_until_taken: no taken branch within %0d cycles", budget);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[32767] = 16'h0000;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        rst = 1'b1; stall = 1'b0; branch = 1'b0; branch_reg = 1'b0; hlt = 1'b0;
        flags = 3'b000; reg_target = 16'h0000;
        m_pc = 16'h0; m_instr = 16'h0; m_pp2 = 16'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_fresh = 1'b0; m_cnt = 0;
        @(negedge clk);

        // Reset then three plain words
        clear_mem();
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_decode();
            sample();
            check_eq("seq_addr", imem_addr, 16'(2 * k));
            if (k == 0) begin
                check_eq("rst_valid", 16'(id_valid), 16'h0);
                check_eq("rst_halted", 16'(halted), 16'h0);
                check_eq("rst_instr", id_instr, 16'h0000);
                check_eq("rst_cnt", branch_cnt, 16'h0000);
            end else begin
                check_eq("seq_valid", 16'(id_valid), 16'h1);
                check_eq("seq_pp2", id_pc_plus2, 16'(2 * k));
            end
            advance();
        end

        // B always, imm9 = -2, at PC 0x0010
        clear_mem();
        mem[8] = 16'hCFFE;
        do_reset();
        run_until_taken(20);
        check_eq("b_taken", 16'(taken), 16'h1);
        check_eq("b_pp2", id_pc_plus2, 16'h0012);
        advance();
        drive_decode(); sample();
        check_eq("b_target", imem_addr, 16'h000E);
        check_eq("b_bubble", 16'(id_valid), 16'h0);
        advance();
        drive_decode(); sample();
        check_eq("b_refill", 16'(id_valid), 16'h1);
        advance();

        // B on Z, Z clear: falls through
        clear_mem();
        mem[8] = 16'hC204;
        flags = 3'b000;
        do_reset();
        run_cycles(9);
        drive_decode(); sample();
        check_eq("bz0_instr", id_instr, 16'hC204);
        check_eq("bz0_taken", 16'(taken), 16'h0);
        advance();
        drive_decode(); sample();
        check_eq("bz0_addr", imem_addr, 16'h0014);
        advance();

        // B on Z, Z set: taken to 0x0012 + 8
        flags = 3'b100;
        do_reset();
        run_until_taken(20);
        check_eq("bz1_taken", 16'(taken), 16'h1);
        advance();
        drive_decode(); sample();
        check_eq("bz1_addr", imem_addr, 16'h001A);
        advance();

        // BR held by a 2-cycle stall, then taken
        clear_mem();
        mem[8] = 16'hD000;
        reg_target = 16'h1234;
        flags = 3'b000;
        do_reset();
        run_cycles(9);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_decode(); sample();
            check_eq("br_stall_taken", 16'(taken), 16'h0);
            check_eq("br_stall_addr", imem_addr, 16'h0012);
            check_eq("br_stall_instr", id_instr, 16'hD000);
            check_eq("br_stall_pp2", id_pc_plus2, 16'h0012);
            advance();
        end
        stall = 1'b0;
        drive_decode(); sample();
        check_eq("br_taken", 16'(taken), 16'h1);
        advance();
        drive_decode(); sample();
        check_eq("br_addr", imem_addr, 16'h1234);
        advance();

        // PC wrap from 0xFFFE to 0x0000
        reg_target = 16'hFFFE;
        do_reset();
        run_until_taken(20);
        advance();
        drive_decode(); sample();
        check_eq("wrap_hi", imem_addr, 16'hFFFE);
        advance();
        drive_decode(); sample();
        check_eq("wrap_lo", imem_addr, 16'h0000);
        check_eq("wrap_pp2", id_pc_plus2, 16'h0000);
        advance();

        // HLT: frozen for 10 cycles with noisy inputs, then reset
        clear_mem();
        mem[8] = 16'hF000;
        do_reset();
        run_cycles(9);
        drive_decode(); sample();
        check_eq("hlt_instr", id_instr, 16'hF000);
        advance();
        for (int k = 0; k < 10; k++) begin
            drive_decode();
            stall      = 1'($urandom_range(0, 1));
            branch     = 1'($urandom_range(0, 1));
            hlt        = 1'b0;
            flags      = 3'($urandom_range(0, 7));
            reg_target = 16'($urandom);
            sample();
            check_eq("hlt_halted", 16'(halted), 16'h1);
            check_eq("hlt_addr", imem_addr, 16'h0012);
            check_eq("hlt_valid", 16'(id_valid), 16'h0);
            check_eq("hlt_taken", 16'(taken), 16'h0);
            advance();
        end
        do_reset();
        drive_decode(); sample();
        check_eq("hlt_rst_addr", imem_addr, 16'h0000);
        check_eq("hlt_rst_halted", 16'(halted), 16'h0);
        advance();

        // 5 taken + 3 not-taken branches
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 16'hCE00;
        for (int i = 5; i < 8; i++) mem[i] = 16'hC000;
        flags = 3'b100;
        do_reset();
        run_cycles(24);
        sample();
`ifdef BRANCH_COUNT_EN
        check_eq("cnt_final", branch_cnt, 16'd5);
`else
        check_eq("cnt_final", branch_cnt, 16'd0);
`endif
        advance();

        // Randomized traffic
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flags = 3'($urandom_range(0, 7));
            reg_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE
                                                     : {15'($urandom), 1'b0};
            drive_decode();
            if ($urandom_range(0, 9) == 0) begin
                branch     = 1'b1;
                branch_reg = 1'($urandom_range(0, 1));
            end
            sample();
            advance();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order: clk in 1 (all state updates on its rising edge); rst in 1 (synchronous, active-high).
REQ-002 The block SHALL have these ports: imem_addr out 16 (fetch address = PC); imem_rdata in 16 (instruction word at imem_addr, same cycle).
REQ-003 The block SHALL have these ports: id_instr out 16 (IF/ID instruction); id_pc_plus2 out 16 (IF/ID PC+2, also the PCS write value); id_valid out 1 (IF/ID holds a live instruction).
REQ-004 The block SHALL have these ports: branch in 1, branch_reg in 1, hlt in 1 (control-unit decodes of id_instr); flags in 3 ({Z,V,N} from the flag register); reg_target in 16 (rs value, for BR).
REQ-005 The block SHALL have these ports: stall in 1 (hazard hold); taken out 1 (branch taken this cycle); halted out 1 (HALTED state); branch_cnt out 16 (taken-branch count).

Function
REQ-006 States SHALL be RUN, STALL and HALTED; STALL SHALL be the state while stall=1 in RUN, returning to RUN when stall=0.
REQ-007 Decoding SHALL use cond=id_instr[11:9] and imm9=id_instr[8:0].
REQ-008 cond SHALL be evaluated as: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-009 taken SHALL be combinational: id_valid & branch & cond true & ~stall & state!=HALTED.
REQ-010 Target for B SHALL be id_pc_plus2 + (sign-extended imm9 << 1), modulo 2^16 (wraps, no fault).
REQ-011 Target for BR (branch_reg=1) SHALL be reg_target.
REQ-012 In RUN with stall=0 and taken=0, each cycle SHALL set PC<=PC+2, IF/ID<={imem_rdata, PC+2}, and id_valid<=1.
REQ-013 On taken=1, PC<=target and id_valid<=0, flushing the wrong-path fetch; branch penalty SHALL be 1 bubble.
REQ-014 stall=1 SHALL hold PC, id_instr, id_pc_plus2 and id_valid unchanged; stall SHALL take priority over branch and hlt, which are re-evaluated after the stall releases.
REQ-015 On id_valid & hlt & ~stall, the block SHALL enter HALTED; PC SHALL freeze at its current value and id_valid<=0.
REQ-016 HALTED SHALL persist, ignoring all inputs except rst; halted=1 in HALTED only.
REQ-017 The PC SHALL wrap from 0xFFFE to 0x0000 silently.
REQ-018 hlt and branch SHALL never both be asserted; if they are, hlt SHALL win and taken=0.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL set PC=0x0000, state=RUN, id_instr=0x0000, id_pc_plus2=0x0000, id_valid=0, halted=0, and branch_cnt=0; this SHALL hold for a reset in any state, including mid-stall and HALTED.
REQ-020 In the first cycle after rst falls, the block SHALL fetch address 0x0000.

Configuration
REQ-021 With BRANCH_COUNT_EN defined, branch_cnt SHALL increment by 1 on each cycle with taken=1 and saturate at 0xFFFF.
REQ-022 With BRANCH_COUNT_EN undefined, no counter logic SHALL be built and branch_cnt SHALL be constant 0x0000.

Verification
REQ-023 Bench SHALL cover: reset, then 3 non-branch words -> imem_addr 0,2,4,6; id_valid=1 from cycle 2; id_pc_plus2 2,4,6.
REQ-024 Bench SHALL cover: B cond=111 imm9=0x1FE at PC 0x0010 -> taken=1, next imem_addr 0x000E, one id_valid=0 bubble.
REQ-025 Bench SHALL cover: B cond=001 with Z=0 -> taken=0, sequential fetch continues; with Z=1 -> taken=1.
REQ-026 Bench SHALL cover: BR with reg_target 0x1234 while stall=1 for 2 cycles -> PC and IF/ID held, no taken; then taken, imem_addr 0x1234.
REQ-027 Bench SHALL cover: HLT -> halted=1, imem_addr frozen, id_valid=0 for 10 cycles; rst -> imem_addr 0x0000, halted=0.
REQ-028 Bench SHALL cover, with BRANCH_COUNT_EN defined: 5 taken plus 3 not-taken branches -> branch_cnt=5; without the macro -> branch_cnt=0.
